// File: rtl/router_slice_pkg.sv
// Shared definitions for the router slice retiming pipeline.
// Provides parameter limits, the occupancy-counter width helper and the
// stage record type {valid, data} sized for the widest legal stage.
package router_slice_pkg;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_DEPTH = 8;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_WIDTH-1:0] data;
    } stage_rec_t;

endpackage

// File: rtl/router_slice_stage.sv
// One elastic register stage of the router slice pipeline.
// Ports:
//   clk, reset (sync, active-high), set (sync, loads SET_VAL into data)
//   up_valid/up_data : word offered by the previous stage (or the pipe input)
//   dn_ready         : next stage (or downstream) takes this stage's word
//   loadable         : this stage can take a word this cycle (combinational)
//   v, d             : registered valid and data of this stage
module router_slice_stage
    import router_slice_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             loadable,
    output logic             v,
    output logic [WIDTH-1:0] d
);

    // Empty, or the current word leaves this cycle.
    assign loadable = !v || dn_ready;

    // Data loads only on an incoming transfer; set freezes all movement.
    always_ff @(posedge clk) begin
        if (reset) begin
            v <= 1'b0;
            d <= '0;
        end else if (set) begin
            d <= SET_VAL;
        end else if (up_valid && loadable) begin
            v <= 1'b1;
            d <= up_data;
        end else if (dn_ready) begin
            v <= 1'b0;
        end
    end

endmodule

// File: rtl/router_slice_pipe_ff.sv
// Elastic WIDTH x DEPTH register pipeline retiming router crossbar outputs
// onto the slice output pins, with valid/ready per stage and slice set/reset.
// Optional macro ROUTER_SLICE_PIPE_OCC_EN adds the registered occ counter.
// Ports:
//   clk                     : single clock, rising edge
//   reset                   : sync active-high, drops all words, clears data
//   set                     : sync active-high, loads SET_VAL into all data
//   in_valid/in_ready/in_data   : upstream handshake (in_ready combinational)
//   out_valid/out_ready/out_data: downstream handshake from the last stage
//   occ                     : occupied stage count (only with the macro)
module router_slice_pipe_ff
    import router_slice_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         set,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef ROUTER_SLICE_PIPE_OCC_EN
    output logic [occ_width(DEPTH)-1:0]  occ,
`endif
    output logic [WIDTH-1:0]             out_data
);

    // Each stage gets its own nets so the ready chain has no self-loop.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_r;
        logic             ld;
        logic             vq;
        logic [WIDTH-1:0] dq;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = g_stage[i-1].vq;
            assign up_d = g_stage[i-1].dq;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_r = out_ready;
        end else begin : g_link
            assign dn_r = g_stage[i+1].ld;
        end

        router_slice_stage #(
            .WIDTH   (WIDTH),
            .SET_VAL (SET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .set      (set),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn_r),
            .loadable (ld),
            .v        (vq),
            .d        (dq)
        );
    end

    // Set and reset block acceptance; the stages already ignore the handshake.
    assign in_ready  = g_stage[0].ld && !set && !reset;
    assign out_valid = g_stage[DEPTH-1].vq;
    assign out_data  = g_stage[DEPTH-1].dq;

`ifdef ROUTER_SLICE_PIPE_OCC_EN
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready && !set;

    // Tracks words in flight; set moves nothing so it leaves the count alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= '0;
        end else if (accept && !emit && (occ != OCC_W'(DEPTH))) begin
            occ <= occ + OCC_W'(1);
        end else if (emit && !accept && (occ != '0)) begin
            occ <= occ - OCC_W'(1);
        end
    end

    occ_bound_a : assert property (@(posedge clk) disable iff (reset)
        (occ <= OCC_W'(DEPTH)) && !(accept && !emit && (occ == OCC_W'(DEPTH))));
`endif

endmodule

// File: tb/tb_router_slice_pipe_ff.sv
// Bench for router_slice_pipe_ff (WIDTH=8, DEPTH=2): directed scenarios then
// random traffic, checked against a slot-level model and an in-order scoreboard.
module tb_router_slice_pipe_ff;
    import router_slice_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned D = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         set = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef ROUTER_SLICE_PIPE_OCC_EN
    logic [occ_width(D)-1:0] occ;
`endif

    always #5 clk = ~clk;

    router_slice_pipe_ff #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .set       (set),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef ROUTER_SLICE_PIPE_OCC_EN
        .occ       (occ),
`endif
        .out_data  (out_data)
    );

    int n_chk = 0;
    int n_err = 0;

    stage_rec_t   mdl [D];
    logic [W-1:0] sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slot i can take a word iff some slot at or after it is empty, or the
    // downstream is taking the last word (the whole pipe then advances).
    function automatic bit can_take(input int i, input bit ordy);
        bit r = ordy;
        for (int j = i; j < int'(D); j++) if (!mdl[j].valid) r = 1'b1;
        return r;
    endfunction

    function automatic int model_occ();
        int n = 0;
        for (int j = 0; j < int'(D); j++) if (mdl[j].valid) n++;
        return n;
    endfunction

    // One clock: drive inputs, check outputs before the edge, advance the model.
    task automatic step(input bit iv, input logic [W-1:0] id, input bit ordy,
                        input bit st, input bit rst, input bit do_chk);
        bit           exp_rdy;
        bit           emit;
        stage_rec_t   nx [D];
        logic [W-1:0] front;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        set       = st;
        reset     = rst;
        #1;
        exp_rdy = !st && !rst && can_take(0, ordy);
        emit    = mdl[D-1].valid && ordy && !st && !rst;
        if (do_chk) begin
            chk("in_ready",  64'(in_ready),  64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(mdl[D-1].valid));
            chk("out_data",  64'(out_data),  mdl[D-1].data);
`ifdef ROUTER_SLICE_PIPE_OCC_EN
            chk("occ", 64'(occ), 64'(model_occ()));
`endif
            if (emit && sb.size() > 0) begin
                front = sb.pop_front();
                chk("order", 64'(out_data), 64'(front));
            end
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < int'(D); i++) mdl[i] = '0;
            sb.delete();
        end else if (st) begin
            for (int i = 0; i < int'(D); i++) mdl[i].data = 64'({W{1'b1}});
            foreach (sb[k]) sb[k] = '1;
        end else begin
            nx = mdl;
            for (int i = 0; i < int'(D); i++) begin
                bit take = can_take(i, ordy);
                bit inc;
                if (i == 0) inc = iv && take;
                else        inc = mdl[i-1].valid && take;
                if (inc) begin
                    nx[i].valid = 1'b1;
                    nx[i].data  = (i == 0) ? 64'(id) : mdl[i-1].data;
                end else if (mdl[i].valid && can_take(i + 1, ordy)) begin
                    nx[i].valid = 1'b0;
                end
            end
            mdl = nx;
            if (iv && exp_rdy) sb.push_back(id);
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) mdl[i] = '0;

        // Reset release with the pipe idle.
        step(0, 8'h00, 0, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1, 0);
        step(0, 8'h00, 1, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 1);

        // Single word: visible two cycles after acceptance, for one cycle.
        step(1, 8'hA5, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);

        // Back-to-back stream at full throughput.
        for (int k = 1; k <= 16; k++) step(1, W'(k), 1, 0, 0, 1);
        for (int k = 0; k < 3; k++)   step(0, 8'h00, 1, 0, 0, 1);

        // Downstream stall, then accept-and-emit in one cycle.
        step(1, 8'h11, 0, 0, 0, 1);
        step(1, 8'h22, 0, 0, 0, 1);
        step(1, 8'h33, 0, 0, 0, 1);
        step(1, 8'h33, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) step(0, 8'h00, 1, 0, 0, 1);

        // Set on a full pipe: data to all-ones, valids kept, no movement.
        step(1, 8'h11, 0, 0, 0, 1);
        step(1, 8'h22, 0, 0, 0, 1);
        step(1, 8'h44, 1, 1, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);

        // Reset together with set while two words are in flight.
        step(1, 8'h5A, 0, 0, 0, 1);
        step(1, 8'h6B, 0, 0, 0, 1);
        step(1, 8'h7C, 1, 1, 1, 1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(1, 8'h81, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);
        step(0, 8'h00, 1, 0, 0, 1);

        // Random traffic with occasional set and reset.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0), 1);
        end
        for (int k = 0; k < 4; k++) step(0, 8'h00, 1, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
